// File: rtl/toe_rx_demux.sv
// ---------------------------------------------------------------------------
// toe_rx_demux
//
// Splits the byte-framed stream that the TCP offload engine writes into the
// receive FIFO into discrete signals:
//   - connection / disconnection events for the session manager
//   - raw FIX message bytes with first/last strobes for the parser
// It also keeps a per-host "connected" bitmap. Payload from a host that is
// not marked connected is swallowed here and never reaches the parser.
//
// Frame format (opcode first):
//   CONNECT    : 0x01, host
//   DISCONNECT : 0x02, host
//   DATA       : 0x03, host, len (1..255), len payload bytes
//
// Ports
//   clk                       clock, everything on the rising edge
//   rst                       synchronous reset, active low
//   fifo_empty_i              receive FIFO empty
//   fifo_data_i[7:0]          FIFO read data, valid the cycle after a read
//   fifo_read_o               FIFO read request
//   connected_o               1-cycle pulse: CONNECT frame decoded
//   connected_host_addr_o     host of the last CONNECT frame (held)
//   disconnected_o            1-cycle pulse: DISCONNECT frame decoded
//   disconnected_host_addr_o  host of the last DISCONNECT frame (held)
//   conn_map_o                bit h set while host h is connected
//   message_o[7:0]            payload byte towards the parser
//   valid_o                   message_o carries a payload byte this cycle
//   new_message_o             pulse with the first payload byte
//   end_message_o             pulse with the last payload byte
//   msg_host_addr_o           source host of the current message (held)
//   error_o                   1-cycle pulse on a framing or host error
//
// FIFO handshake: fifo_read_o is a read request with no backpressure from
// downstream. A byte is taken whenever fifo_read_o is high at a rising edge;
// that byte appears on fifo_data_i during the following cycle, which is
// marked by byte_vld_q. Every valid byte is consumed in the cycle it is
// valid, so the decoder never stalls the FIFO and a gap (empty FIFO) simply
// leaves all state untouched.
// ---------------------------------------------------------------------------
module toe_rx_demux #(
  parameter int NUM_HOST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty_i,
  input  logic [7:0]                 fifo_data_i,
  output logic                       fifo_read_o,
  output logic                       connected_o,
  output logic [NUM_HOST-1:0]        connected_host_addr_o,
  output logic                       disconnected_o,
  output logic [NUM_HOST-1:0]        disconnected_host_addr_o,
  output logic [(2**NUM_HOST)-1:0]   conn_map_o,
  output logic [7:0]                 message_o,
  output logic                       valid_o,
  output logic                       new_message_o,
  output logic                       end_message_o,
  output logic [NUM_HOST-1:0]        msg_host_addr_o,
  output logic                       error_o
);

  localparam int MAP_W = 2**NUM_HOST;

  // Frame opcodes
  localparam logic [7:0] OP_CONNECT    = 8'h01;
  localparam logic [7:0] OP_DISCONNECT = 8'h02;
  localparam logic [7:0] OP_DATA       = 8'h03;

  // Decoder states
  localparam logic [2:0] ST_IDLE    = 3'd0;  // waiting for an opcode
  localparam logic [2:0] ST_HOST_C  = 3'd1;  // host byte of CONNECT
  localparam logic [2:0] ST_HOST_D  = 3'd2;  // host byte of DISCONNECT
  localparam logic [2:0] ST_HOST_M  = 3'd3;  // host byte of DATA
  localparam logic [2:0] ST_LEN     = 3'd4;  // length byte of DATA
  localparam logic [2:0] ST_PAYLOAD = 3'd5;  // payload bytes of DATA

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic                byte_vld_q;

  logic [2:0]          state_q,       state_d;
  logic [7:0]          remaining_q,   remaining_d;
  logic                first_q,       first_d;
  logic                drop_q,        drop_d;
  logic [NUM_HOST-1:0] host_q,        host_d;

  logic                conn_q,        conn_d;
  logic [NUM_HOST-1:0] conn_addr_q,   conn_addr_d;
  logic                disc_q,        disc_d;
  logic [NUM_HOST-1:0] disc_addr_q,   disc_addr_d;
  logic [MAP_W-1:0]    map_q,         map_d;
  logic [7:0]          msg_q,         msg_d;
  logic                valid_q,       valid_d;
  logic                new_q,         new_d;
  logic                end_q,         end_d;
  logic [NUM_HOST-1:0] msg_addr_q,    msg_addr_d;
  logic                err_q,         err_d;

  // Host field of the current byte; upper bits of a host byte are ignored.
  logic [NUM_HOST-1:0] byte_host;
  assign byte_host = fifo_data_i[NUM_HOST-1:0];

  // Read whenever data is available; held low throughout reset so nothing
  // can be in flight when reset is released.
  assign fifo_read_o = rst & ~fifo_empty_i;

  // ---------------------------------------------------------------------
  // Next-state logic: advances only when a byte is valid
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    drop_d      = drop_q;
    host_d      = host_q;

    conn_addr_d = conn_addr_q;
    disc_addr_d = disc_addr_q;
    map_d       = map_q;
    msg_d       = msg_q;
    msg_addr_d  = msg_addr_q;

    // Pulse outputs default low every cycle
    conn_d      = 1'b0;
    disc_d      = 1'b0;
    valid_d     = 1'b0;
    new_d       = 1'b0;
    end_d       = 1'b0;
    err_d       = 1'b0;

    if (byte_vld_q) begin
      case (state_q)
        ST_IDLE: begin
          case (fifo_data_i)
            OP_CONNECT:    state_d = ST_HOST_C;
            OP_DISCONNECT: state_d = ST_HOST_D;
            OP_DATA:       state_d = ST_HOST_M;
            // Unknown opcode: flag it and drop the byte. Staying in IDLE
            // lets the decoder resync on the next recognisable opcode.
            default:       err_d   = 1'b1;
          endcase
        end

        ST_HOST_C: begin
          // Reconnecting an already-connected host still reports the event.
          map_d[byte_host] = 1'b1;
          conn_addr_d      = byte_host;
          conn_d           = 1'b1;
          state_d          = ST_IDLE;
        end

        ST_HOST_D: begin
          map_d[byte_host] = 1'b0;
          disc_addr_d      = byte_host;
          disc_d           = 1'b1;
          state_d          = ST_IDLE;
        end

        ST_HOST_M: begin
          // Connection status is sampled once per frame, at the host byte.
          host_d  = byte_host;
          drop_d  = ~map_q[byte_host];
          state_d = ST_LEN;
        end

        ST_LEN: begin
          if (fifo_data_i == 8'd0) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            remaining_d = fifo_data_i;
            first_d     = 1'b1;
            state_d     = ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          // remaining_q is at least 1 here, so the decrement cannot wrap.
          remaining_d = remaining_q - 8'd1;
          first_d     = 1'b0;
          if (!drop_q) begin
            msg_d   = fifo_data_i;
            valid_d = 1'b1;
            new_d   = first_q;
            end_d   = (remaining_q == 8'd1);
            if (first_q) begin
              msg_addr_d = host_q;
            end
          end else if (remaining_q == 8'd1) begin
            // A swallowed frame is reported once, with its last byte.
            err_d = 1'b1;
          end
          if (remaining_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_vld_q  <= 1'b0;
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      first_q     <= 1'b0;
      drop_q      <= 1'b0;
      host_q      <= '0;
      conn_q      <= 1'b0;
      conn_addr_q <= '0;
      disc_q      <= 1'b0;
      disc_addr_q <= '0;
      map_q       <= '0;
      msg_q       <= 8'd0;
      valid_q     <= 1'b0;
      new_q       <= 1'b0;
      end_q       <= 1'b0;
      msg_addr_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      byte_vld_q  <= fifo_read_o;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      drop_q      <= drop_d;
      host_q      <= host_d;
      conn_q      <= conn_d;
      conn_addr_q <= conn_addr_d;
      disc_q      <= disc_d;
      disc_addr_q <= disc_addr_d;
      map_q       <= map_d;
      msg_q       <= msg_d;
      valid_q     <= valid_d;
      new_q       <= new_d;
      end_q       <= end_d;
      msg_addr_q  <= msg_addr_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all registered
  // ---------------------------------------------------------------------
  assign connected_o              = conn_q;
  assign connected_host_addr_o    = conn_addr_q;
  assign disconnected_o           = disc_q;
  assign disconnected_host_addr_o = disc_addr_q;
  assign conn_map_o               = map_q;
  assign message_o                = msg_q;
  assign valid_o                  = valid_q;
  assign new_message_o            = new_q;
  assign end_message_o            = end_q;
  assign msg_host_addr_o          = msg_addr_q;
  assign error_o                  = err_q;

endmodule

// File: tb/tb_toe_rx_demux.sv
// ---------------------------------------------------------------------------
// tb_toe_rx_demux
//
// Bench for toe_rx_demux. The bench plays the receive FIFO: bytes waiting to
// be read sit in byte_q, and a byte taken at one rising edge is driven on
// fifo_data_i for the following cycle.
//
// Three parts:
//   - a table of short byte streams with the event counts and held output
//     values each one must leave behind;
//   - hand-written sequences for latency, FIFO gaps and reset mid-payload;
//   - random frames checked cycle by cycle against a frame-level model. The
//     model builds each frame itself and records, for every byte it queues,
//     the complete output picture that byte must produce two cycles after
//     it is read.
// ---------------------------------------------------------------------------
module tb_toe_rx_demux;

  localparam int NH = 4;
  localparam int MW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty_i = 1'b1;
  logic [7:0]    fifo_data_i = 8'h00;
  logic          fifo_read_o;
  logic          connected_o;
  logic [NH-1:0] connected_host_addr_o;
  logic          disconnected_o;
  logic [NH-1:0] disconnected_host_addr_o;
  logic [MW-1:0] conn_map_o;
  logic [7:0]    message_o;
  logic          valid_o;
  logic          new_message_o;
  logic          end_message_o;
  logic [NH-1:0] msg_host_addr_o;
  logic          error_o;

  always #5 clk = ~clk;

  toe_rx_demux #(.NUM_HOST(NH)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .fifo_empty_i             (fifo_empty_i),
    .fifo_data_i              (fifo_data_i),
    .fifo_read_o              (fifo_read_o),
    .connected_o              (connected_o),
    .connected_host_addr_o    (connected_host_addr_o),
    .disconnected_o           (disconnected_o),
    .disconnected_host_addr_o (disconnected_host_addr_o),
    .conn_map_o               (conn_map_o),
    .message_o                (message_o),
    .valid_o                  (valid_o),
    .new_message_o            (new_message_o),
    .end_message_o            (end_message_o),
    .msg_host_addr_o          (msg_host_addr_o),
    .error_o                  (error_o)
  );

  // ---------------- types ----------------
  typedef struct packed {
    logic          conn;
    logic          disc;
    logic [NH-1:0] caddr;
    logic [NH-1:0] daddr;
    logic [MW-1:0] map;
    logic [7:0]    msg;
    logic          valid;
    logic          nw;
    logic          en;
    logic [NH-1:0] maddr;
    logic          err;
  } snap_t;

  typedef struct packed {
    logic [3:0]  n;
    logic [63:0] b;       // first byte in [63:56]
    logic [3:0]  e_conn;
    logic [3:0]  e_disc;
    logic [3:0]  e_err;
    logic [3:0]  e_valid;
    logic [3:0]  e_new;
    logic [3:0]  e_end;
    logic [3:0]  e_same;
    logic [15:0] e_map;
    logic [3:0]  e_caddr;
    logic [3:0]  e_daddr;
    logic [3:0]  e_maddr;
    logic [7:0]  e_last;
  } vec_t;

  // ---------------- scoreboard state ----------------
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  byte_q[$];
  snap_t       exp_q[$];
  logic [7:0]  got_q[$];

  snap_t       m;                 // model: held outputs after last queued byte
  snap_t       p1, p2, hold;      // expectation pipeline
  bit          p1v = 0, p2v = 0, pend_v = 0, model_on = 0;
  logic [7:0]  pend_b;
  int          cyc = 0, rd_step = 0, conn_step = 0, disc_step = 0;
  int          n_conn, n_disc, n_err, n_valid, n_new, n_end, n_same;
  logic [7:0]  last_msg;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic snap_t quiet(input snap_t s);
    snap_t r;
    r = s;
    r.conn = 1'b0; r.disc = 1'b0; r.valid = 1'b0;
    r.nw = 1'b0; r.en = 1'b0; r.err = 1'b0;
    return r;
  endfunction

  function automatic snap_t sample();
    snap_t r;
    r.conn = connected_o;          r.disc = disconnected_o;
    r.caddr = connected_host_addr_o; r.daddr = disconnected_host_addr_o;
    r.map = conn_map_o;            r.msg = message_o;
    r.valid = valid_o;             r.nw = new_message_o;
    r.en = end_message_o;          r.maddr = msg_host_addr_o;
    r.err = error_o;
    return r;
  endfunction

  function automatic vec_t mk(input int n, input logic [63:0] b,
                              input int cn, input int dc, input int er, input int vl,
                              input int nw, input int en, input int sm, input logic [15:0] mp,
                              input int ca, input int da, input int ma, input logic [7:0] last);
    vec_t v;
    v.n = 4'(n); v.b = b;
    v.e_conn = 4'(cn); v.e_disc = 4'(dc); v.e_err = 4'(er); v.e_valid = 4'(vl);
    v.e_new = 4'(nw); v.e_end = 4'(en); v.e_same = 4'(sm); v.e_map = mp;
    v.e_caddr = 4'(ca); v.e_daddr = 4'(da); v.e_maddr = 4'(ma); v.e_last = last;
    return v;
  endfunction

  task automatic clr_cnt();
    n_conn = 0; n_disc = 0; n_err = 0; n_valid = 0;
    n_new = 0; n_end = 0; n_same = 0; last_msg = 8'h00;
    got_q.delete();
  endtask

  function automatic void push(input logic [7:0] b, input snap_t s);
    byte_q.push_back(b);
    exp_q.push_back(s);
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit rst_v, input int gap_pct);
    snap_t obs, exp_s;
    @(negedge clk);
    cyc++;
    obs = sample();
    if (connected_o)    begin n_conn++; conn_step = cyc; end
    if (disconnected_o) begin n_disc++; disc_step = cyc; end
    if (error_o)        n_err++;
    if (new_message_o)  n_new++;
    if (end_message_o)  n_end++;
    if (valid_o) begin
      n_valid++;
      last_msg = message_o;
      got_q.push_back(message_o);
      if (new_message_o && end_message_o) n_same++;
    end
    if (model_on) begin
      exp_s = p2v ? p2 : hold;
      if (!exp_s.valid) begin obs.msg = 8'h00; exp_s.msg = 8'h00; end
      check("cycle_outputs", 64'(obs), 64'(exp_s));
      hold = quiet(exp_s);
    end
    p2 = p1; p2v = p1v;
    // Byte read at the previous edge; otherwise junk the DUT must ignore.
    fifo_data_i = pend_v ? pend_b : 8'($urandom);
    pend_v = 0;
    p1v = 0;
    rst = rst_v;
    if (!rst_v) begin
      byte_q.delete(); exp_q.delete();
      p2v = 0; hold = '0; m = '0;
      fifo_empty_i = ($urandom_range(1) == 1);
    end else begin
      fifo_empty_i = (byte_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
    end
    if (rst_v && !fifo_empty_i) begin
      pend_b = byte_q.pop_front();
      p1 = exp_q.pop_front();
      p1v = 1; pend_v = 1; rd_step = cyc;
    end
    #1;
    check("fifo_read", 64'(fifo_read_o), 64'(rst_v && !fifo_empty_i));
  endtask

  // ---------------- frame-level reference model ----------------
  // kind: 0 CONNECT, 1 DISCONNECT, 2 DATA, 3 bad opcode, 4 DATA with len 0
  task automatic gen_frame(input int kind, input int h, input int len);
    snap_t s;
    logic [7:0] b;
    bit drop;
    case (kind)
      0: begin
        push(8'h01, m);
        m.map[h] = 1'b1; m.caddr = 4'(h);
        s = m; s.conn = 1'b1; push(8'(h), s);
      end
      1: begin
        push(8'h02, m);
        m.map[h] = 1'b0; m.daddr = 4'(h);
        s = m; s.disc = 1'b1; push(8'(h), s);
      end
      2: begin
        drop = !m.map[h];
        push(8'h03, m); push(8'(h), m); push(8'(len), m);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          s = m;
          if (!drop) begin
            s.valid = 1'b1; s.msg = b; s.nw = (i == 0); s.en = (i == len - 1);
            s.maddr = 4'(h);
          end else if (i == len - 1) begin
            s.err = 1'b1;
          end
          push(b, s);
          m = quiet(s);
        end
      end
      3: begin
        b = ($urandom_range(1) == 1) ? 8'h00 : 8'($urandom_range(4, 255));
        s = m; s.err = 1'b1; push(b, s);
      end
      default: begin
        push(8'h03, m); push(8'(h), m);
        s = m; s.err = 1'b1; push(8'h00, s);
      end
    endcase
  endtask

  // ---------------- test ----------------
  vec_t vecs[9];

  initial begin
    vec_t        v;
    logic [63:0] bb;
    int          r, kind;

    vecs[0] = mk(2, 64'h0105_0000_0000_0000, 1,0,0,0,0,0,0, 16'h0020, 5,0,0,  8'h00);
    vecs[1] = mk(6, 64'h0305_0338_3D31_0000, 0,0,0,3,1,1,0, 16'h0020, 5,0,5,  8'h31);
    vecs[2] = mk(5, 64'h0307_02AA_BB00_0000, 0,0,1,0,0,0,0, 16'h0020, 5,0,5,  8'h00);
    vecs[3] = mk(2, 64'h0102_0000_0000_0000, 1,0,0,0,0,0,0, 16'h0024, 2,0,5,  8'h00);
    vecs[4] = mk(3, 64'h7F01_0200_0000_0000, 1,0,1,0,0,0,0, 16'h0024, 2,0,5,  8'h00);
    vecs[5] = mk(3, 64'h0302_0000_0000_0000, 0,0,1,0,0,0,0, 16'h0024, 2,0,5,  8'h00);
    vecs[6] = mk(4, 64'h0305_0141_0000_0000, 0,0,0,1,1,1,1, 16'h0024, 2,0,5,  8'h41);
    vecs[7] = mk(6, 64'h0205_0305_0142_0000, 0,1,1,0,0,0,0, 16'h0004, 2,5,5,  8'h00);
    vecs[8] = mk(7, 64'h010F_030F_0210_2000, 1,0,0,2,1,1,0, 16'h8004, 15,5,15, 8'h20);

    m = '0; hold = '0;
    clr_cnt();

    // Reset: every output zero, fifo_read_o low even with data waiting.
    model_on = 1;
    repeat (4) step(0, 0);
    repeat (2) step(1, 0);
    model_on = 0;

    // Table-driven directed streams
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      clr_cnt();
      bb = v.b;
      for (int k = 0; k < int'(v.n); k++) push(bb[63 - 8*k -: 8], '0);
      repeat (int'(v.n) + 4) step(1, 0);
      check($sformatf("v%0d_connected", i),    64'(n_conn),  64'(v.e_conn));
      check($sformatf("v%0d_disconnected", i), 64'(n_disc),  64'(v.e_disc));
      check($sformatf("v%0d_error", i),        64'(n_err),   64'(v.e_err));
      check($sformatf("v%0d_valid", i),        64'(n_valid), 64'(v.e_valid));
      check($sformatf("v%0d_new", i),          64'(n_new),   64'(v.e_new));
      check($sformatf("v%0d_end", i),          64'(n_end),   64'(v.e_end));
      check($sformatf("v%0d_new_end_same", i), 64'(n_same),  64'(v.e_same));
      check($sformatf("v%0d_conn_map", i),     64'(conn_map_o), 64'(v.e_map));
      check($sformatf("v%0d_conn_addr", i),    64'(connected_host_addr_o), 64'(v.e_caddr));
      check($sformatf("v%0d_disc_addr", i),    64'(disconnected_host_addr_o), 64'(v.e_daddr));
      check($sformatf("v%0d_msg_addr", i),     64'(msg_host_addr_o), 64'(v.e_maddr));
      if (v.e_valid != 0) check($sformatf("v%0d_last_byte", i), 64'(last_msg), 64'(v.e_last));
    end

    // Latency: event two cycles after the host byte is read, one cycle wide
    clr_cnt();
    push(8'h02, '0); push(8'h09, '0);
    repeat (6) step(1, 0);
    check("disc_latency", 64'(disc_step - rd_step), 64'd2);
    check("disc_pulse_count", 64'(n_disc), 64'd1);
    check("disc_addr", 64'(disconnected_host_addr_o), 64'd9);

    // Random FIFO gaps during a 10-byte payload
    clr_cnt();
    push(8'h01, '0); push(8'h03, '0);
    push(8'h03, '0); push(8'h03, '0); push(8'h0A, '0);
    for (int k = 0; k < 10; k++) push(8'h50 + 8'(k), '0);
    for (int k = 0; k < 400 && byte_q.size() > 0; k++) step(1, 50);
    check("gap_drain", 64'(byte_q.size()), 64'd0);
    repeat (4) step(1, 0);
    check("gap_valid_count", 64'(n_valid), 64'd10);
    for (int k = 0; k < 10 && k < got_q.size(); k++)
      check($sformatf("gap_byte%0d", k), 64'(got_q[k]), 64'h50 + 64'(k));
    check("gap_new_end", 64'({n_new[3:0], n_end[3:0]}), 64'h11);

    // Reset mid-payload: no end strobe, map cleared, nothing in flight after
    clr_cnt();
    push(8'h03, '0); push(8'h03, '0); push(8'h14, '0);
    for (int k = 0; k < 20; k++) push(8'($urandom), '0);
    repeat (10) step(1, 0);
    repeat (2) step(0, 0);
    check("rst_mid_end", 64'(n_end), 64'd0);
    check("rst_mid_map", 64'(conn_map_o), 64'd0);
    check("rst_mid_outputs", 64'(sample()), 64'd0);
    clr_cnt();
    repeat (4) step(1, 0);
    check("post_rst_quiet", 64'(n_valid + n_err + n_conn + n_disc), 64'd0);

    // Random frames against the model, with gaps and one reset mid-stream
    step(0, 0);
    model_on = 1;
    step(0, 0);
    step(1, 0);
    for (int f = 0; f < 300; f++) begin
      for (int k = 0; k < 2000 && byte_q.size() > 8; k++) step(1, 30);
      if (f == 150) begin
        step(0, 0);
        step(0, 0);
      end
      r = int'($urandom_range(99));
      kind = (r < 20) ? 0 : (r < 40) ? 1 : (r < 88) ? 2 : (r < 94) ? 3 : 4;
      gen_frame(kind, int'($urandom_range(15)),
                ($urandom_range(19) == 0) ? 255 : int'($urandom_range(1, 16)));
    end
    for (int k = 0; k < 5000 && byte_q.size() > 0; k++) step(1, 30);
    check("random_drain", 64'(byte_q.size()), 64'd0);
    repeat (4) step(1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion (cycle %0d)", cyc);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
